uart_rx: RTL
============

// Module: uart_rx
//
// PURPOSE
//   UART receiver, 8N1 (8 data bits LSB first, no parity, 1 stop bit),
//   default 115200 baud from a 12 MHz clock. Receive-side counterpart of
//   uart_tx on the same serial link.
//   Synchronises the rx pin, validates the start bit, samples each bit at
//   mid-period, and presents each byte as a one-cycle valid pulse.
//   Malformed stop bits are flagged as framing errors.
//
// PARAMETERS
//   CLK_FREQ   12_000_000  system clock frequency, Hz
//   BAUD_RATE  115200      line rate, bit/s
//   Derived:
//     CYCLES_PER_BIT = CLK_FREQ/BAUD_RATE   (104 at defaults)
//     HALF_BIT       = CYCLES_PER_BIT/2     (52 at defaults)
//     counter width  = $clog2(CYCLES_PER_BIT)
//
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   rx         in   1  serial input, asynchronous, idle high
//   data       out  8  last correctly framed byte; holds until next good byte
//   valid      out  1  one-cycle pulse: data updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1  high while a frame is in progress (state != IDLE)
//
// BEHAVIOUR
// - Reset values, applied asynchronously on rst_n low:
//   - outputs: data=0, valid=0, frame_err=0, busy=0
//   - internal: state=IDLE, counters=0, sync FFs=1
//   - reset mid-frame abandons the frame; no valid or frame_err is issued.
// - Synchroniser: 2-FF chain gives rx_s, so rx_s lags the pin by 2 cycles.
//   rx_q is rx_s delayed by one cycle, used for edge detection.
// - IDLE:
//   - falling edge (rx_q=1, rx_s=0) -> START, cnt=0.
//   - a constant-low line (break) does not retrigger.
// - START:
//   - cnt counts 0..HALF_BIT-1; decision at cnt==HALF_BIT-1.
//   - sample=0 -> DATA, cnt=0, bit_idx=0.
//   - sample=1 -> IDLE (glitch rejected; no output pulse).
// - DATA:
//   - cnt counts 0..CYCLES_PER_BIT-1; at cnt==CYCLES_PER_BIT-1 the sample
//     shifts into sr[7] (sr shifts right; LSB arrives first).
//   - bit_idx increments per bit; after bit_idx==7 -> STOP, cnt=0.
// - STOP:
//   - at cnt==CYCLES_PER_BIT-1:
//     - sample=1 -> data<=sr, valid=1 for one cycle.
//     - sample=0 -> frame_err=1 for one cycle; data unchanged.
//   - either case -> IDLE.
//   - IDLE is re-entered at mid-stop-bit, so back-to-back frames are
//     accepted with no idle gap.
// - Timing: let T0 be the edge at which IDLE sees the falling edge.
//   - START->DATA at T0+52; DATA->STOP at T0+884.
//   - valid/frame_err high in the cycle after edge T0+988 (default params).
//   - valid and frame_err are never high together.
// - No backpressure: an unread byte is overwritten by the next good frame.
//
// CONFIGURATION
//   UART_RX_MAJORITY_EN
//   - defined: each decision sample (start check, data bits, stop bit) is
//     the 2-of-3 majority of rx_s taken at the decision cycle and the two
//     cycles before it. The decision cycle is unchanged, so timing is
//     identical to the undefined case.
//   - undefined: the single rx_s value at the decision cycle.
//
// TESTING
//   1. Reset release, rx held high for 2000 cycles
//      -> valid=0, frame_err=0, busy=0, data=8'h00 throughout.
//   2. Send 0x55 at 104 cycles/bit
//      -> valid=1 for exactly one cycle, data=8'h55, busy falls with it.
//   3. Send 0xA3 then 0x0F back-to-back, stop bit of 1 bit period
//      -> two valid pulses; data=8'hA3 then 8'h0F.
//   4. Send 0x7E with the stop bit driven low
//      -> frame_err pulse, no valid, data keeps its previous value.
//      Line held low afterwards -> no further activity until a new
//      high->low edge.
//   5. 30-cycle low glitch on idle line -> busy pulses, returns to IDLE,
//      no valid or frame_err. With UART_RX_MAJORITY_EN: 0x3C with a
//      1-cycle inverted spike at every bit centre -> data=8'h3C.
//   6. rst_n asserted mid-byte (during bit 4) -> all outputs 0 immediately.
//      Next frame 0xC9 -> data=8'hC9.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver (8 data bits LSB first, no parity, 1 stop bit).
//
// The asynchronous rx pin goes through a 2-FF synchroniser. A falling edge on
// the idle line starts a frame. The start bit is re-checked at half a bit
// period, and every data bit and the stop bit are sampled at mid-bit.
// A good frame updates 'data' and pulses 'valid' for one cycle. A stop bit
// sampled low pulses 'frame_err' and the byte is dropped.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - each decision sample is the 2-of-3 majority of the
//                         synchronised line over the decision cycle and the
//                         two cycles before it. Decision timing is the same
//                         as in the default build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   // ---------------------------------------------------------------------------
   // Derived timing constants
   // ---------------------------------------------------------------------------
   localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);

   // FSM encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   logic             rx_meta;     // first synchroniser stage (may be metastable)
   logic             rx_s;        // synchronised line
   logic             rx_q;        // rx_s one cycle later, used for edge detection
`ifdef UART_RX_MAJORITY_EN
   logic             rx_q2;       // rx_s two cycles later, third majority vote
`endif

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       sr;

   logic             sample;      // line value used at decision points
   logic             fall_edge;   // idle-to-start transition on the line
   logic             half_done;   // last cycle of the half-bit start check
   logic             bit_done;    // last cycle of a full bit period
   logic             decide;      // a sampling decision is taken this cycle
   logic             stop_decide; // the stop bit is being judged this cycle

   // ---------------------------------------------------------------------------
   // Synchroniser and edge-detect history. Resets to the idle (high) level so
   // that releasing reset cannot look like a start edge.
   // ---------------------------------------------------------------------------
   // NOTE: registers take non-blocking assignments so every stage sees the
   // value from before the clock edge; with blocking assignments the chain
   // would collapse into a single flop.
`ifdef UART_RX_MAJORITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_q    <= 1'b1;
         rx_q2   <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_q    <= rx_s;
         rx_q2   <= rx_q;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_q    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_q    <= rx_s;
      end
   end
`endif

   // Decision sample: a single synchronised value, or a 2-of-3 vote that
   // ignores a one-cycle spike on the line.
   // NOTE: every output of a combinational block gets a value on every path
   // (here the default first); a missed path would infer a latch.
   always_comb begin
      sample = rx_s;
`ifdef UART_RX_MAJORITY_EN
      sample = (rx_s & rx_q) | (rx_s & rx_q2) | (rx_q & rx_q2);
`endif
   end

   // ---------------------------------------------------------------------------
   // Bit-timing strobes
   // ---------------------------------------------------------------------------
   assign fall_edge   = rx_q & ~rx_s;
   assign half_done   = (cnt == CNT_HALF_LAST);
   assign bit_done    = (cnt == CNT_BIT_LAST);
   assign decide      = ((state == START) && half_done) ||
                        (((state == DATA) || (state == STOP)) && bit_done);
   assign stop_decide = (state == STOP) && bit_done;

   // Next-state logic. A low line that never rose again (break) produces no
   // falling edge, so it cannot restart a frame.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (fall_edge) begin
               state_nxt = START;
            end
         end
         START: begin
            if (half_done) begin
               // A start bit that is high again at mid-bit was a glitch
               state_nxt = sample ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_done && (bit_idx == 3'd7)) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            // Back to IDLE at mid-stop-bit, so the next start edge can
            // follow the stop bit directly with no idle gap
            if (bit_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit-period counter: held at zero in IDLE, restarted after every decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if ((state == IDLE) || decide) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Data shift register and bit index; LSB arrives first, so shift right
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_idx <= '0;
      end else if (state == START) begin
         bit_idx <= '0;
      end else if ((state == DATA) && bit_done) begin
         sr      <= {sample, sr[7:1]};
         bit_idx <= bit_idx + 3'd1;
      end
   end

   // Output registers: byte hand-off and one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= stop_decide & sample;
         frame_err <= stop_decide & ~sample;
         if (stop_decide && sample) begin
            data <= sr;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
